// File: rtl/cast_pkg.sv
// Shared definitions for the cast operator family: opcode constants, unpack FSM states
// and beat-count helper.
`ifndef OPCODE_ZEXT
`define OPCODE_ZEXT 26
`endif
`ifndef OPCODE_SEXT
`define OPCODE_SEXT 27
`endif

package cast_pkg;

    localparam int OPCODE_ZEXT = `OPCODE_ZEXT;
    localparam int OPCODE_SEXT = `OPCODE_SEXT;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_t;

    function automatic int num_beats(input int pbw, input int rbw);
        return (pbw + rbw - 1) / rbw;
    endfunction

endpackage

// File: rtl/width_unpack_op_if.sv
// Operand-in / beat-out handshake bundle for width_unpack_op.
interface width_unpack_op_if #(
    parameter int ParamBitWidth  = 32,
    parameter int ReturnBitWidth = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ParamBitWidth-1:0]  lhs;
    logic                      out_valid;
    logic                      out_ready;
    logic [ReturnBitWidth-1:0] ret;
    logic                      ret_last;

    modport slave (
        input  in_valid, lhs, out_ready,
        output in_ready, out_valid, ret, ret_last
    );

    modport master (
        output in_valid, lhs, out_ready,
        input  in_ready, out_valid, ret, ret_last
    );
endinterface

// File: rtl/width_unpack_op_unpack_ext.sv
// Combinational zero/sign extension of the operand to a whole number of output beats.
module unpack_ext
    import cast_pkg::*;
#(
    parameter int ParamOpCode   = OPCODE_ZEXT,
    parameter int ParamBitWidth = 32,
    parameter int ExtWidth      = 32
) (
    input  logic [ParamBitWidth-1:0] lhs,
    output logic [ExtWidth-1:0]      ext
);
    if (ExtWidth == ParamBitWidth) begin : g_exact
        assign ext = lhs;
    end else if (ParamOpCode == OPCODE_SEXT) begin : g_sext
        assign ext = {{(ExtWidth - ParamBitWidth){lhs[ParamBitWidth-1]}}, lhs};
    end else begin : g_zext
        assign ext = {{(ExtWidth - ParamBitWidth){1'b0}}, lhs};
    end
endmodule

// File: rtl/width_unpack_op.sv
// Splits one wide operand into ReturnBitWidth-bit beats over a valid/ready stream.
// Define WIDTH_UNPACK_MSB_FIRST_EN to emit the most significant chunk first.
module width_unpack_op
    import cast_pkg::*;
#(
    parameter int ParamOpCode    = OPCODE_ZEXT,
    parameter int ParamBitWidth  = 32,
    parameter int ReturnBitWidth = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    width_unpack_op_if.slave  bus,
    output logic              busy
);
    localparam int NB = num_beats(ParamBitWidth, ReturnBitWidth);
    localparam int EW = NB * ReturnBitWidth;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

    if (ParamOpCode != OPCODE_ZEXT && ParamOpCode != OPCODE_SEXT) begin : g_bad_opcode
        $error("width_unpack_op: illegal ParamOpCode %0d", ParamOpCode);
    end

    unpack_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [EW-1:0] sreg;
    logic [EW-1:0] sreg_shift;
    logic [EW-1:0] ext;
    logic          last;
    logic          accept;
    logic          beat;

    unpack_ext #(
        .ParamOpCode  (ParamOpCode),
        .ParamBitWidth(ParamBitWidth),
        .ExtWidth     (EW)
    ) u_ext (
        .lhs(bus.lhs),
        .ext(ext)
    );

`ifdef WIDTH_UNPACK_MSB_FIRST_EN
    assign bus.ret    = sreg[EW-1 -: ReturnBitWidth];
    assign sreg_shift = sreg << ReturnBitWidth;
`else
    assign bus.ret    = sreg[ReturnBitWidth-1:0];
    assign sreg_shift = sreg >> ReturnBitWidth;
`endif

    assign last          = (state == SEND) && (cnt == LAST_CNT);
    assign bus.ret_last  = last;
    assign bus.out_valid = enable && (state == SEND);
    // Ready on the last beat's handshake cycle lets the next operand follow with no bubble.
    assign bus.in_ready  = enable && ((state == IDLE) || (bus.out_ready && last));
    assign accept        = bus.in_valid && bus.in_ready;
    assign beat          = bus.out_valid && bus.out_ready;
    assign busy          = (state == SEND);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SEND;
            SEND:    if (beat && last && !accept) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (accept) begin
            cnt  <= '0;
            sreg <= ext;
        end else if (beat) begin
            cnt  <= last ? '0 : cnt + 1'b1;
            sreg <= sreg_shift;
        end
    end
endmodule

// File: tb/tb_width_unpack_op.sv
// Directed bench for width_unpack_op: several configurations side by side, beat order
// follows WIDTH_UNPACK_MSB_FIRST_EN when defined.
module tb_width_unpack_op;
    import cast_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy0, busy1, busy2, busy3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    width_unpack_op_if #(.ParamBitWidth(32), .ReturnBitWidth(8)) b0 ();
    width_unpack_op_if #(.ParamBitWidth(12), .ReturnBitWidth(8)) b1 ();
    width_unpack_op_if #(.ParamBitWidth(12), .ReturnBitWidth(8)) b2 ();
    width_unpack_op_if #(.ParamBitWidth(4),  .ReturnBitWidth(8)) b3 ();

    width_unpack_op #(.ParamOpCode(OPCODE_ZEXT), .ParamBitWidth(32), .ReturnBitWidth(8)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .bus(b0), .busy(busy0));
    width_unpack_op #(.ParamOpCode(OPCODE_SEXT), .ParamBitWidth(12), .ReturnBitWidth(8)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .bus(b1), .busy(busy1));
    width_unpack_op #(.ParamOpCode(OPCODE_ZEXT), .ParamBitWidth(12), .ReturnBitWidth(8)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .bus(b2), .busy(busy2));
    width_unpack_op #(.ParamOpCode(OPCODE_SEXT), .ParamBitWidth(4),  .ReturnBitWidth(8)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .bus(b3), .busy(busy3));

    // Beat k of an already-extended value, in emission order.
    function automatic logic [7:0] chunk(input logic [31:0] v, input int k, input int nb);
        int idx;
`ifdef WIDTH_UNPACK_MSB_FIRST_EN
        idx = nb - 1 - k;
`else
        idx = k;
`endif
        return v[idx*8 +: 8];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        b0.in_valid = 0; b0.lhs = '0; b0.out_ready = 1;
        b1.in_valid = 0; b1.lhs = '0; b1.out_ready = 1;
        b2.in_valid = 0; b2.lhs = '0; b2.out_ready = 1;
        b3.in_valid = 0; b3.lhs = '0; b3.out_ready = 1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b0.out_valid); end
        if (b0.ret !== 8'h00) begin errors++; $display("FAIL rst_ret got %h want 00", b0.ret); end
        if (b0.ret_last !== 1'b0) begin errors++; $display("FAIL rst_ret_last got %b want 0", b0.ret_last); end
        if ({busy0, busy1, busy2, busy3} !== 4'b0) begin errors++; $display("FAIL rst_busy got %b want 0000", {busy0, busy1, busy2, busy3}); end
        if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", b0.in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zext32();
        logic [31:0] v = 32'hA1B2C3D4;
        b0.in_valid = 1; b0.lhs = v; b0.out_ready = 1;
        #1;
        checks++;
        if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL z32_in_ready got %b want 1", b0.in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b0.in_valid = 0;
            checks += 3;
            if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL z32_valid[%0d] got %b want 1", k, b0.out_valid); end
            if (b0.ret !== chunk(v, k, 4)) begin errors++; $display("FAIL z32_ret[%0d] got %h want %h", k, b0.ret, chunk(v, k, 4)); end
            if (b0.ret_last !== (k == 3)) begin errors++; $display("FAIL z32_last[%0d] got %b want %b", k, b0.ret_last, (k == 3)); end
        end
        @(negedge clk);
        checks += 2;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL z32_idle_valid got %b want 0", b0.out_valid); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL z32_idle_busy got %b want 0", busy0); end
    endtask

    task automatic test_ext12();
        logic [31:0] vs = 32'h0000F9AB;
        logic [31:0] vz = 32'h000009AB;
        b1.in_valid = 1; b1.lhs = 12'h9AB;
        b2.in_valid = 1; b2.lhs = 12'h9AB;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b1.in_valid = 0; b2.in_valid = 0;
            checks += 4;
            if (b1.ret !== chunk(vs, k, 2)) begin errors++; $display("FAIL sext12_ret[%0d] got %h want %h", k, b1.ret, chunk(vs, k, 2)); end
            if (b2.ret !== chunk(vz, k, 2)) begin errors++; $display("FAIL zext12_ret[%0d] got %h want %h", k, b2.ret, chunk(vz, k, 2)); end
            if (b1.ret_last !== (k == 1)) begin errors++; $display("FAIL sext12_last[%0d] got %b want %b", k, b1.ret_last, (k == 1)); end
            if ({b1.out_valid, b2.out_valid} !== 2'b11) begin errors++; $display("FAIL ext12_valid[%0d] got %b want 11", k, {b1.out_valid, b2.out_valid}); end
        end
        @(negedge clk);
        checks++;
        if ({b1.out_valid, b2.out_valid} !== 2'b00) begin errors++; $display("FAIL ext12_idle got %b want 00", {b1.out_valid, b2.out_valid}); end
    endtask

    task automatic test_single_beat();
        b3.in_valid = 1; b3.lhs = 4'hA;
        @(negedge clk);
        b3.in_valid = 0;
        checks += 3;
        if (b3.ret !== 8'hFA) begin errors++; $display("FAIL nb1_ret got %h want fa", b3.ret); end
        if (b3.ret_last !== 1'b1) begin errors++; $display("FAIL nb1_last got %b want 1", b3.ret_last); end
        if (b3.out_valid !== 1'b1) begin errors++; $display("FAIL nb1_valid got %b want 1", b3.out_valid); end
        @(negedge clk);
        checks++;
        if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL nb1_idle got %b want 0", b3.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] v = 32'hA1B2C3D4;
        b0.in_valid = 1; b0.lhs = v; b0.out_ready = 1;
        for (int c = 0; c < 7; c++) begin
            int k;
            @(negedge clk);
            b0.in_valid = 0;
            k = (c < 1) ? c : (c < 5) ? 1 : c - 3;
            checks += 3;
            if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[c%0d] got %b want 1", c, b0.out_valid); end
            if (b0.ret !== chunk(v, k, 4)) begin errors++; $display("FAIL bp_ret[c%0d] got %h want %h", c, b0.ret, chunk(v, k, 4)); end
            if (b0.ret_last !== (k == 3)) begin errors++; $display("FAIL bp_last[c%0d] got %b want %b", c, b0.ret_last, (k == 3)); end
            if (c == 1) b0.out_ready = 0;
            if (c == 4) b0.out_ready = 1;
        end
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", b0.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0 = 32'h11223344;
        logic [31:0] w1 = 32'h55667788;
        b0.in_valid = 1; b0.lhs = w0; b0.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            @(negedge clk);
            if (i == 0) b0.lhs = w1;
            if (i == 4) b0.in_valid = 0;
            #1;
            w = (i < 4) ? w0 : w1;
            checks += 4;
            if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, b0.out_valid); end
            if (b0.ret !== chunk(w, i % 4, 4)) begin errors++; $display("FAIL b2b_ret[%0d] got %h want %h", i, b0.ret, chunk(w, i % 4, 4)); end
            if (b0.ret_last !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", i, b0.ret_last, (i % 4 == 3)); end
            if (b0.in_ready !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want %b", i, b0.in_ready, (i % 4 == 3)); end
        end
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", b0.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v  = 32'hA1B2C3D4;
        logic [31:0] v2 = 32'hDEADBEEF;
        b0.in_valid = 1; b0.lhs = v; b0.out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            b0.in_valid = 0;
        end
        checks++;
        if (b0.ret !== chunk(v, 2, 4)) begin errors++; $display("FAIL rmid_pre got %h want %h", b0.ret, chunk(v, 2, 4)); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", b0.out_valid); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy0); end
        if (b0.ret !== 8'h00) begin errors++; $display("FAIL rmid_ret got %h want 00", b0.ret); end
        @(negedge clk);
        rst = 1'b0;
        b0.in_valid = 1; b0.lhs = v2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b0.in_valid = 0;
            checks += 2;
            if (b0.ret !== chunk(v2, k, 4)) begin errors++; $display("FAIL rmid_ret[%0d] got %h want %h", k, b0.ret, chunk(v2, k, 4)); end
            if (b0.ret_last !== (k == 3)) begin errors++; $display("FAIL rmid_last[%0d] got %b want %b", k, b0.ret_last, (k == 3)); end
        end
        @(negedge clk);
    endtask

    task automatic test_enable();
        logic [31:0] v = 32'hA1B2C3D4;
        b0.in_valid = 1; b0.lhs = v; b0.out_ready = 1;
        @(negedge clk);
        b0.in_valid = 0;
        enable = 1'b0;
        #1;
        checks += 2;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL en_valid got %b want 0", b0.out_valid); end
        if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready got %b want 0", b0.in_ready); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL en_busy got %b want 1", busy0); end
        enable = 1'b1;
        #1;
        checks += 2;
        if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL en_resume_valid got %b want 1", b0.out_valid); end
        if (b0.ret !== chunk(v, 0, 4)) begin errors++; $display("FAIL en_resume_ret got %h want %h", b0.ret, chunk(v, 0, 4)); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (b0.ret !== chunk(v, k, 4)) begin errors++; $display("FAIL en_ret[%0d] got %h want %h", k, b0.ret, chunk(v, k, 4)); end
        end
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL en_idle got %b want 0", b0.out_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zext32();
        test_ext12();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
